root_scheduler: RTL

- Shares one fixed-point n-th-root engine between N_REQ requesters.
- Arbitrates round-robin, latches one job, and holds the engine operands stable for the whole computation.
- Pulses the engine start, waits for completion with a watchdog, and returns a tagged result over a valid/ready response channel.
- Sits between the request fabric and the root engine; the engine is untouched.

---
 rtl/root_scheduler_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/root_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/root_scheduler_pkg.sv
// Shared definitions for the root-engine scheduler: FSM states, operand and result formats,
// and the degree code that the scheduler rejects without starting the engine.
package root_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FLUSH,
    ST_RESP
  } state_t;

  localparam int unsigned RAD_W  = 10;
  localparam int unsigned DEG_W  = 3;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned RES_W  = 2 * FRAC_W;

  localparam logic [RES_W-1:0] ONE     = 20'h00400;
  localparam logic [DEG_W-1:0] DEG_ERR = 3'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer, with the pointer
// advancing past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  localparam logic [ID_W:0]   NUM  = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   idx;
  logic            found;

  // Scan N_REQ slots starting at ptr; idx wraps by a single subtraction.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W + 1)'(i);
      if (idx >= NUM) idx = idx - NUM;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found                  = 1'b1;
        grant[idx[ID_W-1:0]]   = 1'b1;
        grant_id               = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/root_scheduler.sv
// Shares one n-th-root engine between N_REQ requesters: round-robin grant, single job in flight,
// watchdog-guarded wait with engine flush, and a tagged valid/ready response.
module root_scheduler
  import root_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [RAD_W*N_REQ-1:0] req_radicand,
  input  logic [DEG_W*N_REQ-1:0] req_degree,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [RES_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   eng_in_valid,
  output logic [RAD_W-1:0]       eng_in_data_1,
  output logic [DEG_W-1:0]       eng_in_data_2,
  output logic                   eng_rst_n,
  input  logic                   eng_out_valid,
  input  logic [RES_W-1:0]       eng_out_data
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t           state;
  logic [TO_W-1:0]  wd;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             in_idle;
  logic             xfer;
  logic [RAD_W-1:0] rad_sel;
  logic [DEG_W-1:0] deg_sel;

  assign in_idle   = (state == ST_IDLE);
  assign xfer      = in_idle && (|grant);
  assign req_ready = in_idle ? grant : '0;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (in_idle),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  always_comb begin
    rad_sel = '0;
    deg_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        rad_sel = req_radicand[RAD_W*i +: RAD_W];
        deg_sel = req_degree[DEG_W*i +: DEG_W];
      end
    end
  end

  // Engine operands are only loaded on a new accepted job, so they stay frozen through
  // ISSUE, WAIT and FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      wd            <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      eng_in_valid  <= 1'b0;
      eng_in_data_1 <= '0;
      eng_in_data_2 <= '0;
      eng_rst_n     <= 1'b0;
    end else begin
      eng_in_valid <= 1'b0;
      eng_rst_n    <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (xfer) begin
            rsp_id <= grant_id;
            if (deg_sel == DEG_ERR) begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              eng_in_data_1 <= rad_sel;
              eng_in_data_2 <= deg_sel;
              eng_in_valid  <= 1'b1;
              state         <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the final watchdog cycle still beats the flush.
          if (eng_out_valid) begin
            rsp_data  <= eng_out_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (wd == WD_LAST) begin
            eng_rst_n <= 1'b0;
            state     <= ST_FLUSH;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_FLUSH: begin
          rsp_data  <= '0;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
